// File: rtl/crc16_t_if.sv
// Byte-stream bus for crc16_t: transfer-layer side (tx_lt_*) and downstream encoder side (tx_*).
// The slave modport is the generator's view; the master modport is the driving environment.
interface crc16_t_if;
  logic       tx_lt_sop;
  logic       tx_lt_eop;
  logic       tx_lt_valid;
  logic       tx_lt_ready;
  logic [7:0] tx_lt_data;
  logic       tx_sop;
  logic       tx_eop;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;

  modport slave (
    input  tx_lt_sop, tx_lt_eop, tx_lt_valid, tx_lt_data, tx_ready,
    output tx_lt_ready, tx_sop, tx_eop, tx_valid, tx_data
  );

  modport master (
    output tx_lt_sop, tx_lt_eop, tx_lt_valid, tx_lt_data, tx_ready,
    input  tx_lt_ready, tx_sop, tx_eop, tx_valid, tx_data
  );
endinterface

// File: rtl/crc16_t.sv
// Transmit DATA-phase CRC16/USB generator: forwards PID and payload bytes through a single
// output register and appends ~CRC (low byte, then high byte with tx_eop).
module crc16_t (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     tx_data_on,
  output logic     tx_sop_en,
  output logic     tx_eop_en,
  crc16_t_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_CRC_LO  = 2'd2,
    S_CRC_HI  = 2'd3
  } state_t;

  // Reflected CRC16 (0xA001 form), one byte LSB-first.
  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_crc;
  logic [15:0] w_crc_nxt;
  logic        r_valid;
  logic        r_sop;
  logic        r_eop;
  logic [7:0]  r_data;
  logic        w_slot_free;
  logic        w_lt_ready;
  logic        w_accept;
  logic        w_load;
  logic [7:0]  w_ld_data;
  logic        w_ld_sop;
  logic        w_ld_eop;
  logic        w_sop_en;

  // Upstream ready is forced low during reset so nothing is consumed before the block is live.
  assign w_slot_free = !r_valid || bus.tx_ready;
  assign w_lt_ready  = rst_n && tx_data_on && w_slot_free &&
                       ((r_state == S_IDLE) || (r_state == S_PAYLOAD));
  assign w_accept    = w_lt_ready && bus.tx_lt_valid;

  assign bus.tx_lt_ready = w_lt_ready;
  assign bus.tx_valid    = r_valid;
  assign bus.tx_sop      = r_sop;
  assign bus.tx_eop      = r_eop;
  assign bus.tx_data     = r_data;
  assign tx_sop_en       = w_sop_en;
  assign tx_eop_en       = r_valid && bus.tx_ready && r_eop;

  // Next-state, CRC update and output-register load selection.
  always_comb begin
    w_state_nxt = r_state;
    w_crc_nxt   = r_crc;
    w_load      = 1'b0;
    w_ld_data   = 8'h00;
    w_ld_sop    = 1'b0;
    w_ld_eop    = 1'b0;
    w_sop_en    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && bus.tx_lt_sop) begin
          w_crc_nxt   = 16'hFFFF;
          w_load      = 1'b1;
          w_ld_data   = bus.tx_lt_data;
          w_ld_sop    = 1'b1;
          w_sop_en    = 1'b1;
          w_state_nxt = bus.tx_lt_eop ? S_CRC_LO : S_PAYLOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PAYLOAD: begin
        if (w_accept) begin
          w_crc_nxt   = crc16_next(r_crc, bus.tx_lt_data);
          w_load      = 1'b1;
          w_ld_data   = bus.tx_lt_data;
          w_state_nxt = bus.tx_lt_eop ? S_CRC_LO : S_PAYLOAD;
        end else begin
          w_state_nxt = S_PAYLOAD;
        end
      end
      S_CRC_LO: begin
        if (w_slot_free) begin
          w_load      = 1'b1;
          w_ld_data   = ~r_crc[7:0];
          w_state_nxt = S_CRC_HI;
        end else begin
          w_state_nxt = S_CRC_LO;
        end
      end
      S_CRC_HI: begin
        if (w_slot_free) begin
          w_load      = 1'b1;
          w_ld_data   = ~r_crc[15:8];
          w_ld_eop    = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_CRC_HI;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and running CRC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_crc   <= 16'hFFFF;
    end else begin
      r_state <= w_state_nxt;
      r_crc   <= w_crc_nxt;
    end
  end

  // Output register: load wins, otherwise a downstream accept empties the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_data  <= 8'h00;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_sop   <= w_ld_sop;
      r_eop   <= w_ld_eop;
      r_data  <= w_ld_data;
    end else if (r_valid && bus.tx_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

endmodule

// File: tb/tb_crc16_t.sv
// Scoreboard bench for crc16_t: packets are expanded into expected output beats by a
// reference model; an independent monitor checks every downstream accept against the queue.
module tb_crc16_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx_data_on = 1'b0;
  logic tx_sop_en;
  logic tx_eop_en;

  crc16_t_if bus();

  crc16_t dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data_on (tx_data_on),
    .tx_sop_en  (tx_sop_en),
    .tx_eop_en  (tx_eop_en),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } beat_t;

  beat_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ready_mode = 0;
  int exp_sop_en = 0;
  int exp_eop_en = 0;
  int sop_en_cnt = 0;
  int eop_en_cnt = 0;
  int last_sop_cyc = 0;
  int last_eop_cyc = 0;

  // CRC16/USB computed the non-reflected way on bit-reversed bytes, result reversed and inverted.
  function automatic logic [15:0] ref_crc(input logic [7:0] b[$]);
    logic [15:0] c;
    logic [15:0] r;
    logic [7:0]  rb;
    c = 16'hFFFF;
    foreach (b[i]) begin
      for (int k = 0; k < 8; k++) rb[k] = b[i][7-k];
      c = c ^ {rb, 8'h00};
      for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
    end
    for (int k = 0; k < 16; k++) r[k] = c[15-k];
    return ~r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Downstream ready pattern: steady, alternating, or random.
  initial begin
    bus.tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.tx_ready = 1'b1;
        1:       bus.tx_ready = ~bus.tx_ready;
        default: bus.tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops on each downstream accept, checks backpressure stability and counts pulses.
  logic [9:0] prev_beat;
  logic       prev_stall = 1'b0;
  always @(negedge clk) begin
    beat_t e;
    cyc++;
    if (rst_n) begin
      if (prev_stall) begin
        chk("hold_valid", 32'(bus.tx_valid), 32'd1);
        chk("hold_beat", 32'({bus.tx_data, bus.tx_sop, bus.tx_eop}), 32'(prev_beat));
      end
      if (bus.tx_valid && !bus.tx_ready) chk("bp_lt_ready", 32'(bus.tx_lt_ready), 32'd0);
      if (tx_sop_en) sop_en_cnt++;
      if (tx_eop_en) eop_en_cnt++;
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h with nothing expected", bus.tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat", 32'({bus.tx_data, bus.tx_sop, bus.tx_eop}), 32'(e));
          if (bus.tx_sop) last_sop_cyc = cyc;
          if (bus.tx_eop) last_eop_cyc = cyc;
        end
      end
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_beat  = {bus.tx_data, bus.tx_sop, bus.tx_eop};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
    int  n;
    logic got;
    n = 0;
    got = 1'b0;
    bus.tx_lt_data  = d;
    bus.tx_lt_sop   = s;
    bus.tx_lt_eop   = e;
    bus.tx_lt_valid = 1'b1;
    while (!got && n < 500) begin
      @(negedge clk);
      got = bus.tx_lt_ready;
      n++;
      @(posedge clk);
      #1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: byte %0h not accepted within %0d cycles", d, n);
    end
    bus.tx_lt_valid = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] pid, input logic [7:0] pl[$],
                             input int gap_at, input bit rand_gaps);
    logic [15:0] crc;
    crc = ref_crc(pl);
    exp_q.push_back(beat_t'{pid, 1'b1, 1'b0});
    foreach (pl[i]) exp_q.push_back(beat_t'{pl[i], 1'b0, 1'b0});
    exp_q.push_back(beat_t'{crc[7:0], 1'b0, 1'b0});
    exp_q.push_back(beat_t'{crc[15:8], 1'b0, 1'b1});
    exp_sop_en++;
    exp_eop_en++;
    send_byte(pid, 1'b1, pl.size() == 0);
    foreach (pl[i]) begin
      if (rand_gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      if (i == gap_at) begin
        tx_data_on      = 1'b0;
        bus.tx_lt_data  = pl[i];
        bus.tx_lt_sop   = 1'b0;
        bus.tx_lt_eop   = (i == pl.size() - 1);
        bus.tx_lt_valid = 1'b1;
        repeat (5) begin
          @(negedge clk);
          chk("gap_lt_ready", 32'(bus.tx_lt_ready), 32'd0);
          @(posedge clk);
          #1;
        end
        tx_data_on = 1'b1;
      end
      send_byte(pl[i], 1'b0, i == pl.size() - 1);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string name);
    chk({name, "_valid"}, 32'(bus.tx_valid), 32'd0);
    chk({name, "_sop"}, 32'(bus.tx_sop), 32'd0);
    chk({name, "_eop"}, 32'(bus.tx_eop), 32'd0);
    chk({name, "_data"}, 32'(bus.tx_data), 32'd0);
    chk({name, "_lt_ready"}, 32'(bus.tx_lt_ready), 32'd0);
    chk({name, "_sop_en"}, 32'(tx_sop_en), 32'd0);
    chk({name, "_eop_en"}, 32'(tx_eop_en), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] digits[$];
    logic [7:0] pl[$];
    logic [7:0] empty_pl[$];
    int len;
    int gap;

    bus.tx_lt_sop   = 1'b0;
    bus.tx_lt_eop   = 1'b0;
    bus.tx_lt_valid = 1'b0;
    bus.tx_lt_data  = 8'h00;
    for (int i = 0; i < 9; i++) digits.push_back(8'(8'h31 + i));
    chk("ref_model_check", 32'(ref_crc(digits)), 32'h0000B4C8);

    // Reset state, with a valid upstream byte presented.
    tx_data_on = 1'b1;
    bus.tx_lt_valid = 1'b1;
    bus.tx_lt_sop   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    bus.tx_lt_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // PID-only packet.
    send_packet(8'h4B, empty_pl, -1, 1'b0);
    wait_drain();
    chk("pid_only_span", 32'(last_eop_cyc - last_sop_cyc), 32'd2);

    // "123456789" streamed.
    send_packet(8'hC3, digits, -1, 1'b0);
    wait_drain();
    chk("stream_span", 32'(last_eop_cyc - last_sop_cyc), 32'd11);

    // Same with alternating downstream ready.
    ready_mode = 1;
    send_packet(8'hC3, digits, -1, 1'b0);
    wait_drain();
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Junk bytes without sop in IDLE are dropped.
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    send_packet(8'hC3, digits, -1, 1'b0);
    wait_drain();
    chk("junk_stream_span", 32'(last_eop_cyc - last_sop_cyc), 32'd11);

    // tx_data_on gap after 4 payload bytes.
    send_packet(8'hC3, digits, 4, 1'b0);
    wait_drain();

    // Reset after 3 payload bytes, third byte still in the output register.
    exp_q.push_back(beat_t'{8'hC3, 1'b1, 1'b0});
    exp_q.push_back(beat_t'{8'h31, 1'b0, 1'b0});
    exp_q.push_back(beat_t'{8'h32, 1'b0, 1'b0});
    exp_sop_en++;
    send_byte(8'hC3, 1'b1, 1'b0);
    send_byte(8'h31, 1'b0, 1'b0);
    send_byte(8'h32, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    chk("pre_reset_valid", 32'(bus.tx_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_quiet("mid_reset");
    chk("reset_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_packet(8'hC3, digits, -1, 1'b0);
    wait_drain();
    chk("post_reset_span", 32'(last_eop_cyc - last_sop_cyc), 32'd11);

    // Randomized packets, ready patterns, junk bytes and enable gaps.
    for (int p = 0; p < 30; p++) begin
      ready_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 4) == 0) send_byte(8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
      len = $urandom_range(0, 16);
      pl.delete();
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      gap = (len > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : -1;
      send_packet(8'($urandom), pl, gap, 1'b1);
    end
    wait_drain();
    repeat (3) @(posedge clk);
    #1;

    chk("sop_en_count", 32'(sop_en_cnt), 32'(exp_sop_en));
    chk("eop_en_count", 32'(eop_en_cnt), 32'(exp_eop_en));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
